// File: rtl/pin_in_sync_if.sv
// Pin-conditioning bus: raw pad levels and filter controls in, conditioned
// levels, edge pulses and glitch count out.
interface pin_in_sync_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FILT_BITS = 4,
    parameter int unsigned GCNT_BITS = 16
);
    logic [WIDTH-1:0]     pin_raw;
    logic [WIDTH-1:0]     filt_en;
    logic [FILT_BITS-1:0] filt_len;
    logic                 glitch_clr;
    logic [WIDTH-1:0]     pin_in;
    logic [WIDTH-1:0]     pin_rise;
    logic [WIDTH-1:0]     pin_fall;
    logic [GCNT_BITS-1:0] glitch_cnt;

    // Driver side (pads / configuration), sees the conditioned results.
    modport master (
        output pin_raw, filt_en, filt_len, glitch_clr,
        input  pin_in, pin_rise, pin_fall, glitch_cnt
    );

    // Conditioning block side.
    modport slave (
        input  pin_raw, filt_en, filt_len, glitch_clr,
        output pin_in, pin_rise, pin_fall, glitch_cnt
    );
endinterface

// File: rtl/pin_in_sync.sv
// Pin input conditioning: synchronises raw pad levels into the cog clock
// domain, applies an optional per-pin stability filter, emits registered
// rise/fall pulses and keeps a saturating count of rejected-glitch cycles.
module pin_in_sync #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_BITS   = 4,
    parameter int unsigned GCNT_BITS   = 16
) (
    input  logic         clk_cog,
    input  logic         res,
    pin_in_sync_if.slave bus
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_out;
    logic [WIDTH-1:0]                  pin_q, pin_d;
    logic [WIDTH-1:0]                  rise_q, fall_q;
    logic [WIDTH-1:0][FILT_BITS-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]                  glitch_ev;
    logic [GCNT_BITS-1:0]              gcnt_q, gcnt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Plain flop chain per pin; nothing may sit between stages.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= bus.pin_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Per-pin filter: a disagreement must persist filt_len+1 samples to commit.
    // filt_len is compared live, so lowering it mid-count commits at once.
    always_comb begin
        pin_d     = pin_q;
        cnt_d     = cnt_q;
        glitch_ev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!bus.filt_en[i]) begin
                // Bypass also discards any partial count without flagging a glitch.
                pin_d[i] = sync_out[i];
                cnt_d[i] = '0;
            end else if (sync_out[i] == pin_q[i]) begin
                cnt_d[i]     = '0;
                glitch_ev[i] = (cnt_q[i] != '0);
            end else if (cnt_q[i] >= bus.filt_len) begin
                pin_d[i] = sync_out[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + FILT_BITS'(1);
            end
        end
    end

    // Glitch counter: clear wins over a coincident glitch; saturates at all-ones.
    always_comb begin
        gcnt_d = gcnt_q;
        if (bus.glitch_clr) begin
            gcnt_d = '0;
        end else if ((|glitch_ev) && (gcnt_q != '1)) begin
            gcnt_d = gcnt_q + GCNT_BITS'(1);
        end
    end

    // Conditioned state; pulses are derived from the pending change so they
    // line up with the cycle pin_in first shows its new value.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            pin_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '0;
            gcnt_q <= '0;
        end else begin
            pin_q  <= pin_d;
            rise_q <= pin_d & ~pin_q;
            fall_q <= ~pin_d & pin_q;
            cnt_q  <= cnt_d;
            gcnt_q <= gcnt_d;
        end
    end

    assign bus.pin_in     = pin_q;
    assign bus.pin_rise   = rise_q;
    assign bus.pin_fall   = fall_q;
    assign bus.glitch_cnt = gcnt_q;

endmodule

// File: tb/tb_pin_in_sync.sv
// Directed bench for pin_in_sync. A second instance with a 4-bit glitch
// counter shares the stimulus so counter saturation is reached quickly.
module tb_pin_in_sync;

    logic        clk_cog = 1'b0;
    logic        res     = 1'b1;
    logic [31:0] pin_raw = '0;
    logic [31:0] filt_en = '0;
    logic [3:0]  filt_len = '0;
    logic        glitch_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    pin_in_sync_if #(.WIDTH(32), .FILT_BITS(4), .GCNT_BITS(16)) bus ();
    pin_in_sync_if #(.WIDTH(32), .FILT_BITS(4), .GCNT_BITS(4))  bus_s ();

    assign bus.pin_raw      = pin_raw;
    assign bus.filt_en      = filt_en;
    assign bus.filt_len     = filt_len;
    assign bus.glitch_clr   = glitch_clr;
    assign bus_s.pin_raw    = pin_raw;
    assign bus_s.filt_en    = filt_en;
    assign bus_s.filt_len   = filt_len;
    assign bus_s.glitch_clr = glitch_clr;

    pin_in_sync #(.WIDTH(32), .SYNC_STAGES(2), .FILT_BITS(4), .GCNT_BITS(16)) dut (
        .clk_cog (clk_cog),
        .res     (res),
        .bus     (bus)
    );

    pin_in_sync #(.WIDTH(32), .SYNC_STAGES(2), .FILT_BITS(4), .GCNT_BITS(4)) dut_s (
        .clk_cog (clk_cog),
        .res     (res),
        .bus     (bus_s)
    );

    always #5 clk_cog = ~clk_cog;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_cog);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_in, input logic [31:0] e_rise,
                           input logic [31:0] e_fall, input logic [15:0] e_gcnt);
        chk({tag, ".pin_in"}, bus.pin_in, e_in);
        chk({tag, ".pin_rise"}, bus.pin_rise, e_rise);
        chk({tag, ".pin_fall"}, bus.pin_fall, e_fall);
        chk({tag, ".glitch_cnt"}, {16'h0, bus.glitch_cnt}, {16'h0, e_gcnt});
    endtask

    // One-cycle high pulse on mask; with filt_len=1 the glitch lands on the 4th edge.
    task automatic pulse(input logic [31:0] mask);
        pin_raw = pin_raw | mask;
        tick(1);
        pin_raw = pin_raw & ~mask;
        tick(3);
    endtask

    initial begin
        // Reset
        tick(2);
        chk_out("reset", 32'h0, 32'h0, 32'h0, 16'h0);
        res = 1'b0;
        tick(1);

        // 1: bypass latency on pin 5
        pin_raw = 32'h0000_0020;
        tick(1);
        chk_out("byp_n", 32'h0, 32'h0, 32'h0, 16'h0);
        tick(1);
        chk("byp_n1.pin_in", bus.pin_in, 32'h0);
        tick(1);
        chk_out("byp_n2", 32'h20, 32'h20, 32'h0, 16'h0);
        tick(1);
        chk_out("byp_n3", 32'h20, 32'h0, 32'h0, 16'h0);

        // 2: filter reject (3 samples) then accept (4 samples) on pin 3
        filt_en  = 32'h0000_0008;
        filt_len = 4'd3;
        pin_raw  = pin_raw | 32'h8;
        tick(3);
        pin_raw  = pin_raw & ~32'h8;
        tick(2);
        chk_out("rej_n4", 32'h20, 32'h0, 32'h0, 16'h0);
        tick(1);
        chk_out("rej_n5", 32'h20, 32'h0, 32'h0, 16'h1);
        pin_raw  = pin_raw | 32'h8;
        tick(4);
        chk("acc_n3.pin_in", bus.pin_in, 32'h20);
        pin_raw  = pin_raw & ~32'h8;
        tick(1);
        chk("acc_n4.pin_in", bus.pin_in, 32'h20);
        tick(1);
        chk_out("acc_n5", 32'h28, 32'h8, 32'h0, 16'h1);
        tick(3);
        chk_out("acc_n8", 32'h28, 32'h0, 32'h0, 16'h1);
        tick(1);
        chk_out("acc_fall", 32'h20, 32'h0, 32'h8, 16'h1);

        // 3a: pins 0, 7, 31 glitch in the same cycle -> +1 only
        filt_en  = 32'h8000_0081;
        filt_len = 4'd1;
        pin_raw  = pin_raw | 32'h8000_0081;
        tick(1);
        pin_raw  = pin_raw & ~32'h8000_0081;
        tick(2);
        chk("sim_n2.glitch_cnt", {16'h0, bus.glitch_cnt}, 32'h1);
        tick(1);
        chk_out("sim_n3", 32'h20, 32'h0, 32'h0, 16'h2);

        // 3b: saturation, observed on the 4-bit instance
        for (int p = 0; p < 20; p++) begin
            pulse(32'h0000_0001);
        end
        chk("sat.glitch_cnt", {16'h0, bus.glitch_cnt}, 32'd22);
        chk("sat.small_cnt", {28'h0, bus_s.glitch_cnt}, 32'hF);
        pulse(32'h0000_0080);
        chk("sat2.small_cnt", {28'h0, bus_s.glitch_cnt}, 32'hF);
        chk("sat2.glitch_cnt", {16'h0, bus.glitch_cnt}, 32'd23);

        // 4a: lower filt_len below a running count -> commit next edge
        filt_en  = 32'h8000_0281;
        filt_len = 4'd15;
        pin_raw  = pin_raw | 32'h200;
        tick(10);
        chk("len_n9.pin_in", bus.pin_in, 32'h20);
        filt_len = 4'd2;
        tick(1);
        chk_out("len_commit", 32'h220, 32'h200, 32'h0, 16'd23);

        // 4b: drop filt_en mid-count -> bypass same cycle, no glitch
        filt_en  = 32'h8000_0681;
        filt_len = 4'd15;
        pin_raw  = pin_raw | 32'h400;
        tick(7);
        chk("en_n6.pin_in", bus.pin_in, 32'h220);
        filt_en  = 32'h8000_0281;
        tick(1);
        chk_out("en_drop", 32'h620, 32'h400, 32'h0, 16'd23);
        tick(1);
        chk_out("en_after", 32'h620, 32'h0, 32'h0, 16'd23);

        // 5: reset mid-operation, then bypassed all-ones after release
        filt_en  = 32'hFFFF_FFFF;
        filt_len = 4'd7;
        pin_raw  = 32'hFFFF_FFFF;
        tick(4);
        chk("pre_res.pin_in", bus.pin_in, 32'h620);
        res = 1'b1;
        tick(1);
        chk_out("res_mid", 32'h0, 32'h0, 32'h0, 16'h0);
        chk("res_mid.small_cnt", {28'h0, bus_s.glitch_cnt}, 32'h0);
        res     = 1'b0;
        filt_en = 32'h0;
        tick(2);
        chk_out("rel_n1", 32'h0, 32'h0, 32'h0, 16'h0);
        tick(1);
        chk_out("rel_n2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 16'h0);
        tick(1);
        chk_out("rel_n3", 32'hFFFF_FFFF, 32'h0, 32'h0, 16'h0);

        // 6: fall path on pin 12 with filt_len=1
        filt_en  = 32'h0000_1000;
        filt_len = 4'd1;
        pin_raw  = 32'hFFFF_EFFF;
        tick(3);
        chk_out("fall_n2", 32'hFFFF_FFFF, 32'h0, 32'h0, 16'h0);
        tick(1);
        chk_out("fall_n3", 32'hFFFF_EFFF, 32'h0, 32'h1000, 16'h0);
        tick(1);
        chk_out("fall_n4", 32'hFFFF_EFFF, 32'h0, 32'h0, 16'h0);

        // 3c: glitch_clr coincident with a glitch -> 0
        filt_en = 32'h0000_0001;
        pin_raw = 32'hFFFF_EFFE;
        tick(1);
        pin_raw = 32'hFFFF_EFFF;
        tick(3);
        chk_out("clr_pre", 32'hFFFF_EFFF, 32'h0, 32'h0, 16'h1);
        pin_raw = 32'hFFFF_EFFE;
        tick(1);
        pin_raw = 32'hFFFF_EFFF;
        tick(2);
        glitch_clr = 1'b1;
        tick(1);
        chk("clr_hit.glitch_cnt", {16'h0, bus.glitch_cnt}, 32'h0);
        chk("clr_hit.small_cnt", {28'h0, bus_s.glitch_cnt}, 32'h0);
        glitch_clr = 1'b0;
        tick(1);
        chk_out("clr_after", 32'hFFFF_EFFF, 32'h0, 32'h0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
